// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multicycle main FSM and the datapath.
// The slave modport is the FSM side; the master modport is the datapath side.
// With MULTICYCLE_FSM_MEM_WAIT_EN defined, the bundle also carries mem_ready.
interface multicycle_main_fsm_if #(
  parameter int unsigned STATE_W = 4
);
  logic [6:0]         op;
  logic               pcUpdate;
  logic               branch;
  logic               regWrite;
  logic               memWrite;
  logic               irWrite;
  logic               adrSrc;
  logic [1:0]         resultSrc;
  logic [1:0]         aluSrcA;
  logic [1:0]         aluSrcB;
  logic [1:0]         aluOp;
  logic               illegal;
  logic [STATE_W-1:0] state;
`ifdef MULTICYCLE_FSM_MEM_WAIT_EN
  logic               mem_ready;

  modport master (
    output op, mem_ready,
    input  pcUpdate, branch, regWrite, memWrite, irWrite, adrSrc,
           resultSrc, aluSrcA, aluSrcB, aluOp, illegal, state
  );

  modport slave (
    input  op, mem_ready,
    output pcUpdate, branch, regWrite, memWrite, irWrite, adrSrc,
           resultSrc, aluSrcA, aluSrcB, aluOp, illegal, state
  );
`else
  modport master (
    output op,
    input  pcUpdate, branch, regWrite, memWrite, irWrite, adrSrc,
           resultSrc, aluSrcA, aluSrcB, aluOp, illegal, state
  );

  modport slave (
    input  op,
    output pcUpdate, branch, regWrite, memWrite, irWrite, adrSrc,
           resultSrc, aluSrcA, aluSrcB, aluOp, illegal, state
  );
`endif
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/
// execute/writeback and drives the datapath selects, strobes and aluOp.
// Optional feature macro: MULTICYCLE_FSM_MEM_WAIT_EN (FETCH, MEMREAD and
// MEMWRITE stall on mem_ready=0).
module multicycle_main_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_main_fsm_if.slave bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECR    = STATE_W'(6),
    S_EXECI    = STATE_W'(7),
    S_ALUWB    = STATE_W'(8),
    S_JAL      = STATE_W'(9),
    S_BEQ      = STATE_W'(10)
  } state_t;

  state_t     r_state;
  state_t     w_next;
  state_t     w_dec;
  logic       w_mem_ready;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_reg_write;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_adr_src;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_illegal;

`ifdef MULTICYCLE_FSM_MEM_WAIT_EN
  assign w_mem_ready = bus.mem_ready;
`else
  assign w_mem_ready = 1'b1;
`endif

  // While reset is held the selects decode as FETCH regardless of r_state.
  assign w_dec = reset ? S_FETCH : r_state;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode; illegal is the only op-dependent output.
  always_comb begin
    w_next       = S_FETCH;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_illegal    = 1'b0;
    case (w_dec)
      S_FETCH: begin
        w_adr_src    = 1'b0;
        w_ir_write   = w_mem_ready;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b10;
        w_alu_op     = 2'b00;
        w_result_src = 2'b10;
        w_pc_update  = w_mem_ready;
        w_next       = w_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b00;
        case (bus.op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_JAL:            w_next = S_JAL;
          OP_BEQ:            w_next = S_BEQ;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b00;
        w_next      = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_result_src = 2'b00;
        w_adr_src    = 1'b1;
        w_next       = w_mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_result_src = 2'b00;
        w_adr_src    = 1'b1;
        w_mem_write  = 1'b1;
        w_next       = w_mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b00;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_result_src = 2'b00;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_JAL: begin
        w_alu_src_a  = 2'b01;
        w_alu_src_b  = 2'b10;
        w_alu_op     = 2'b00;
        w_result_src = 2'b00;
        w_pc_update  = 1'b1;
        w_next       = S_ALUWB;
      end
      S_BEQ: begin
        w_alu_src_a  = 2'b10;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b01;
        w_result_src = 2'b00;
        w_branch     = 1'b1;
        w_next       = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
    if (reset) begin
      w_pc_update = 1'b0;
      w_branch    = 1'b0;
      w_reg_write = 1'b0;
      w_mem_write = 1'b0;
      w_ir_write  = 1'b0;
      w_illegal   = 1'b0;
    end
  end

  assign bus.pcUpdate  = w_pc_update;
  assign bus.branch    = w_branch;
  assign bus.regWrite  = w_reg_write;
  assign bus.memWrite  = w_mem_write;
  assign bus.irWrite   = w_ir_write;
  assign bus.adrSrc    = w_adr_src;
  assign bus.resultSrc = w_result_src;
  assign bus.aluSrcA   = w_alu_src_a;
  assign bus.aluSrcB   = w_alu_src_b;
  assign bus.aluOp     = w_alu_op;
  assign bus.illegal   = w_illegal;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: per-cycle state and control
// outputs compared against an instruction-level reference model.
module tb_multicycle_main_fsm;

  localparam int unsigned STATE_W = 4;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef struct packed {
    logic       pc;
    logic       br;
    logic       rw;
    logic       mw;
    logic       ir;
    logic       adr;
    logic [1:0] res;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] aop;
    logic       ill;
  } ctrl_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  multicycle_main_fsm_if #(.STATE_W(STATE_W)) bus ();

  multicycle_main_fsm #(.STATE_W(STATE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: sequence of states visited by one instruction, FETCH first.
  function automatic void model_trace(input logic [6:0] op, output int tr[$]);
    tr = '{0, 1};
    case (op)
      OP_LOAD:  tr = '{0, 1, 2, 3, 4};
      OP_STORE: tr = '{0, 1, 2, 5};
      OP_RTYPE: tr = '{0, 1, 6, 8};
      OP_ITYPE: tr = '{0, 1, 7, 8};
      OP_JAL:   tr = '{0, 1, 9, 8};
      OP_BEQ:   tr = '{0, 1, 10};
      default:  tr = '{0, 1};
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_JAL) || (op == OP_BEQ);
  endfunction

  // Reference: control values the datapath should see in a given state.
  function automatic ctrl_t exp_ctrl(input int st, input bit ill, input bit rdy, input bit rst);
    ctrl_t c;
    c = '0;
    case (st)
      0:  begin c.pc = rdy; c.ir = rdy; c.res = 2'b10; c.b = 2'b10; end
      1:  begin c.a = 2'b01; c.b = 2'b01; c.ill = ill; end
      2:  begin c.a = 2'b10; c.b = 2'b01; end
      3:  begin c.adr = 1'b1; end
      4:  begin c.res = 2'b01; c.rw = 1'b1; end
      5:  begin c.adr = 1'b1; c.mw = 1'b1; end
      6:  begin c.a = 2'b10; c.aop = 2'b10; end
      7:  begin c.a = 2'b10; c.b = 2'b01; c.aop = 2'b10; end
      8:  begin c.rw = 1'b1; end
      9:  begin c.a = 2'b01; c.b = 2'b10; c.pc = 1'b1; end
      10: begin c.a = 2'b10; c.aop = 2'b01; c.br = 1'b1; end
      default: c = '0;
    endcase
    if (rst) begin
      c.pc = 1'b0; c.br = 1'b0; c.rw = 1'b0; c.mw = 1'b0; c.ir = 1'b0; c.ill = 1'b0;
    end
    return c;
  endfunction

  function automatic ctrl_t get_ctrl();
    ctrl_t c;
    c.pc  = bus.pcUpdate;
    c.br  = bus.branch;
    c.rw  = bus.regWrite;
    c.mw  = bus.memWrite;
    c.ir  = bus.irWrite;
    c.adr = bus.adrSrc;
    c.res = bus.resultSrc;
    c.a   = bus.aluSrcA;
    c.b   = bus.aluSrcB;
    c.aop = bus.aluOp;
    c.ill = bus.illegal;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held two cycles: state 0, strobes low; FETCH strobes right after release.
  task automatic test_reset();
    ctrl_t exp;
    ctrl_t obs;
    reset  = 1'b1;
    bus.op = OP_RTYPE;
`ifdef MULTICYCLE_FSM_MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
    for (int c = 0; c < 2; c++) begin
      tick();
      exp = exp_ctrl(0, 1'b0, 1'b1, 1'b1);
      obs = get_ctrl();
      checks++;
      if (bus.state !== STATE_W'(0) || obs !== exp) begin
        failures++;
        $display("FAIL reset cycle %0d: state=%0d ctrl=%h, expected state=0 ctrl=%h", c, bus.state, obs, exp);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.irWrite !== 1'b1 || bus.pcUpdate !== 1'b1 || bus.state !== STATE_W'(0)) begin
      failures++;
      $display("FAIL reset_release: irWrite=%b pcUpdate=%b state=%0d, expected 1 1 0", bus.irWrite, bus.pcUpdate, bus.state);
    end
  endtask

  // Directed opcodes then random ones, back to back, with junk op outside sampling states.
  task automatic test_instr_stream();
    logic [6:0] ops[$];
    int         tr[$];
    int         st;
    int         waits;
    bit         rdy;
    bit         ill;
    ctrl_t      exp;
    ctrl_t      obs;
    logic [6:0] legal[6];
    legal = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ};
    ops = '{OP_RTYPE, OP_LOAD, OP_STORE, OP_BEQ, OP_JAL, OP_ITYPE, 7'b1111111, OP_LOAD, OP_STORE};
    for (int k = 0; k < 60; k++) begin
      int r;
      r = int'($urandom_range(0, 7));
      if (r < 6) ops.push_back(legal[r]);
      else       ops.push_back(7'($urandom));
    end
    foreach (ops[n]) begin
      model_trace(ops[n], tr);
      ill = !is_legal(ops[n]);
      foreach (tr[i]) begin
        st    = tr[i];
        waits = 0;
`ifdef MULTICYCLE_FSM_MEM_WAIT_EN
        if (st == 0 || st == 3 || st == 5) waits = int'($urandom_range(0, 2));
`endif
        for (int w = 0; w <= waits; w++) begin
          rdy    = (w == waits);
          bus.op = (st == 1 || st == 2) ? ops[n] : 7'($urandom);
`ifdef MULTICYCLE_FSM_MEM_WAIT_EN
          bus.mem_ready = rdy;
`endif
          @(negedge clk);
          exp = exp_ctrl(st, ill, rdy, 1'b0);
          obs = get_ctrl();
          checks++;
          if (bus.state !== STATE_W'(st) || obs !== exp) begin
            failures++;
            $display("FAIL stream op=%b step %0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                     ops[n], i, bus.state, obs, st, exp);
          end
          tick();
        end
      end
    end
  endtask

  // Reset in MEMREAD of a lw aborts to FETCH without a register write.
  task automatic test_mid_reset();
    int    tr[$];
    bit    rw_seen;
    ctrl_t exp;
    ctrl_t obs;
    rw_seen = 1'b0;
    tr = '{0, 1, 2};
`ifdef MULTICYCLE_FSM_MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
    foreach (tr[i]) begin
      bus.op = OP_LOAD;
      @(negedge clk);
      rw_seen = rw_seen | bus.regWrite;
      checks++;
      if (bus.state !== STATE_W'(tr[i])) begin
        failures++;
        $display("FAIL mid_reset_lead step %0d: state=%0d, expected %0d", i, bus.state, tr[i]);
      end
      tick();
    end
    reset = 1'b1;
    @(negedge clk);
    rw_seen = rw_seen | bus.regWrite;
    exp = exp_ctrl(0, 1'b0, 1'b1, 1'b1);
    obs = get_ctrl();
    checks++;
    if (bus.state !== STATE_W'(3) || obs !== exp) begin
      failures++;
      $display("FAIL mid_reset_memread: state=%0d ctrl=%h, expected state=3 ctrl=%h", bus.state, obs, exp);
    end
    tick();
    reset = 1'b0;
    bus.op = 7'b1111111;
    @(negedge clk);
    rw_seen = rw_seen | bus.regWrite;
    exp = exp_ctrl(0, 1'b0, 1'b1, 1'b0);
    obs = get_ctrl();
    checks++;
    if (bus.state !== STATE_W'(0) || obs !== exp) begin
      failures++;
      $display("FAIL mid_reset_fetch: state=%0d ctrl=%h, expected state=0 ctrl=%h", bus.state, obs, exp);
    end
    tick();
    @(negedge clk);
    rw_seen = rw_seen | bus.regWrite;
    checks++;
    if (bus.state !== STATE_W'(1) || bus.illegal !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_decode: state=%0d illegal=%b, expected state=1 illegal=1", bus.state, bus.illegal);
    end
    tick();
    checks++;
    if (rw_seen !== 1'b0 || bus.state !== STATE_W'(0)) begin
      failures++;
      $display("FAIL mid_reset_nowrite: regWrite_seen=%b state=%0d, expected 0 and 0", rw_seen, bus.state);
    end
  endtask

`ifdef MULTICYCLE_FSM_MEM_WAIT_EN
  // Three FETCH wait cycles then a lw: 8 cycles FETCH to FETCH.
  task automatic test_mem_wait();
    int cycles;
    bus.op = OP_LOAD;
    for (int c = 0; c < 3; c++) begin
      bus.mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.state !== STATE_W'(0) || bus.irWrite !== 1'b0 || bus.pcUpdate !== 1'b0) begin
        failures++;
        $display("FAIL mem_wait_fetch %0d: state=%0d irWrite=%b pcUpdate=%b, expected 0 0 0",
                 c, bus.state, bus.irWrite, bus.pcUpdate);
      end
      tick();
    end
    bus.mem_ready = 1'b1;
    cycles = 3;
    while (cycles < 20) begin
      @(negedge clk);
      if (cycles == 3) begin
        checks++;
        if (bus.irWrite !== 1'b1 || bus.pcUpdate !== 1'b1) begin
          failures++;
          $display("FAIL mem_wait_ready: irWrite=%b pcUpdate=%b, expected 1 1", bus.irWrite, bus.pcUpdate);
        end
      end
      tick();
      cycles++;
      if (bus.state == STATE_W'(0)) break;
    end
    checks++;
    if (cycles != 8) begin
      failures++;
      $display("FAIL mem_wait_lw_cycles: took %0d cycles, expected 8", cycles);
    end
  endtask
`endif

  initial begin
    reset  = 1'b1;
    bus.op = 7'd0;
`ifdef MULTICYCLE_FSM_MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
    test_reset();
    test_instr_stream();
    test_mid_reset();
`ifdef MULTICYCLE_FSM_MEM_WAIT_EN
    test_mem_wait();
`endif
    test_instr_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences the shared datapath (PC, IR, register file, single ALU, unified memory) through fetch/decode/execute/writeback.
- Produces mux selects, write strobes and the 2-bit aluOp consumed by the existing ALU decoder. The ALU decoder turns aluOp together with funct3/funct7 into the 3-bit ALU control.
- Sits in controlUnit beside the ALU decoder; instantiated by the top-level control unit.

Parameters:
- STATE_W, 4: width of the state register; must be >= 4.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  7  opcode, instr[6:0] from the instruction register.
- pcUpdate  output  1  PC write strobe (unconditional).
- branch  output  1  qualifies the PC write with the ALU zero flag (beq).
- regWrite  output  1  register-file write strobe.
- memWrite  output  1  data-memory write strobe.
- irWrite  output  1  instruction register / oldPC load strobe.
- adrSrc  output  1  memory address select: 0=PC, 1=ALU result register.
- resultSrc  output  2  result mux select: 00=ALUOut, 01=Data, 10=ALU result.
- aluSrcA  output  2  ALU A select: 00=PC, 01=oldPC, 10=rs1.
- aluSrcB  output  2  ALU B select: 00=rs2, 01=immExt, 10=constant 4.
- aluOp  output  2  to the ALU decoder: 00=add, 01=sub/branch, 10=funct-decoded.
- illegal  output  1  one-cycle pulse on an unsupported opcode.
- state  output  STATE_W  current state, exported for debug.

Behaviour:
- Reset is synchronous. With reset high at a rising edge: state <= FETCH.
- While reset is high, pcUpdate, irWrite, regWrite, memWrite, branch and illegal are forced to 0. Selects show FETCH values.
- Outputs are Moore, decoded from state only. Any output not listed for a state is 0.
- FETCH (0):
  - adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10, pcUpdate=1.
  - Next: DECODE.
- DECODE (1):
  - aluSrcA=01, aluSrcB=01, aluOp=00 (branch target precompute).
  - Next by op:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECR.
    - 0010011 -> EXECI.
    - 1101111 -> JAL.
    - 1100011 -> BEQ.
    - Anything else -> FETCH, with illegal=1 for this one cycle (Mealy on op; the only non-Moore output).
- MEMADR (2): aluSrcA=10, aluSrcB=01, aluOp=00. Next: op==0000011 -> MEMREAD, else MEMWRITE.
- MEMREAD (3): resultSrc=00, adrSrc=1. Next: MEMWB.
- MEMWB (4): resultSrc=01, regWrite=1. Next: FETCH.
- MEMWRITE (5): resultSrc=00, adrSrc=1, memWrite=1. Next: FETCH.
- EXECR (6): aluSrcA=10, aluSrcB=00, aluOp=10. Next: ALUWB.
- EXECI (7): aluSrcA=10, aluSrcB=01, aluOp=10. Next: ALUWB.
- ALUWB (8): resultSrc=00, regWrite=1. Next: FETCH.
- JAL (9): aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1. Next: ALUWB.
- BEQ (10): aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1. Next: FETCH.
- Unused encodings (11..15): all outputs 0, next state FETCH (self-recovery).
- Cycles per instruction, FETCH to FETCH:
  - lw 5.
  - sw, R-type, I-type, jal 4.
  - beq 3.
  - illegal 2.
- op is sampled only in DECODE and MEMADR. Changes in other states are ignored.
- Reset asserted mid-instruction aborts at the next edge with no further strobes. The first post-reset cycle is FETCH.

Optional Feature:
- Macro: MULTICYCLE_FSM_MEM_WAIT_EN.
- Defined:
  - Adds input mem_ready (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold their state while mem_ready=0.
  - In FETCH, irWrite and pcUpdate are asserted only in the cycle mem_ready=1.
  - memWrite stays high throughout MEMWRITE until the mem_ready=1 cycle, then the FSM advances.
  - Each wait cycle adds 1 to the cycle counts above.
- Undefined: no mem_ready port; memory is treated as single-cycle; behaviour exactly as in Behaviour.

Test Plan:
- Reset: hold reset 2 cycles with op=0110011 -> state=0 and all strobes 0 during reset; first cycle after release irWrite=1, pcUpdate=1.
- R-type: op=0110011 -> states 0,1,6,8,0; aluOp=10 in EXECR; regWrite=1 only in ALUWB; 4 cycles.
- lw then sw:
  - op=0000011 -> 0,1,2,3,4; regWrite and resultSrc=01 in MEMWB.
  - op=0100011 -> 0,1,2,5; memWrite=1 exactly one cycle.
- beq and jal:
  - op=1100011 -> 0,1,10 with branch=1, aluOp=01.
  - op=1101111 -> 0,1,9,8 with pcUpdate=1 in JAL.
- Illegal and mid-instruction reset:
  - op=1111111 -> DECODE illegal=1 one cycle, then FETCH.
  - reset asserted in MEMREAD -> next state FETCH, regWrite never 1.
- With MULTICYCLE_FSM_MEM_WAIT_EN: mem_ready=0 for 3 cycles in FETCH -> state stays 0 and irWrite=0; irWrite=1 on the 4th cycle (mem_ready=1); lw takes 8 cycles.
